// File: rtl/br_update_queue_pkg.sv
// Shared branch-predictor definitions for the PHT update queue: sizes,
// 2-bit counter encodings and the queued entry layout.
package br_update_queue_pkg;

  localparam int DEPTH     = 16;
  localparam int LOG_DEPTH = 4;
  localparam int LOG_INDEX = 10;
  localparam int ENTRY_W   = LOG_INDEX + 1;

  // 2-bit saturating counter encodings shared with the PHT itself.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } pht_ctr_e;

  // One in-flight predicted branch: the PHT slot it used and what it guessed.
  typedef struct packed {
    logic [LOG_INDEX-1:0] pht_index;
    logic                 pred_dir;
  } uq_entry_t;

endpackage

// File: rtl/br_update_queue_if.sv
// Fetch push, retire and PHT update signals of the branch update queue.
interface br_update_queue_if;
  import br_update_queue_pkg::*;

  logic                 fe_push_i;
  logic [LOG_INDEX-1:0] fe_pht_index_i;
  logic                 fe_pred_dir_i;
  logic                 fe_ready_o;
  logic                 rt_valid_i;
  logic                 rt_brdir_i;
  logic                 flush_i;
  logic [LOG_INDEX-1:0] pht_wt_index_o;
  logic                 pht_cm_brdir_we_o;
  logic                 pht_cm_brdir_o;
  logic                 br_mispredict_o;
  logic [LOG_DEPTH:0]   count_o;
  logic                 underflow_err_o;

  // Pipeline side: drives fetch/retire/flush, observes the queue.
  modport master (
    output fe_push_i, fe_pht_index_i, fe_pred_dir_i,
    output rt_valid_i, rt_brdir_i, flush_i,
    input  fe_ready_o, pht_wt_index_o, pht_cm_brdir_we_o, pht_cm_brdir_o,
    input  br_mispredict_o, count_o, underflow_err_o
  );

  // Queue side.
  modport slave (
    input  fe_push_i, fe_pht_index_i, fe_pred_dir_i,
    input  rt_valid_i, rt_brdir_i, flush_i,
    output fe_ready_o, pht_wt_index_o, pht_cm_brdir_we_o, pht_cm_brdir_o,
    output br_mispredict_o, count_o, underflow_err_o
  );

endinterface

// File: rtl/br_update_queue_ram.sv
// Entry storage for the update queue: one write port, one asynchronous
// read port, deliberately not reset (pointers alone define validity).
module br_uq_ram
  import br_update_queue_pkg::*;
(
  input  logic                 clock,
  input  logic                 we,
  input  logic [LOG_DEPTH-1:0] waddr,
  input  logic [ENTRY_W-1:0]   wdata,
  input  logic [LOG_DEPTH-1:0] raddr,
  output logic [ENTRY_W-1:0]   rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Capture a pushed entry at the tail slot.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/br_update_queue.sv
// Commit-side PHT writer: fetch queues the index/prediction of every
// predicted branch, retire pops in order with the resolved direction and
// the block issues a registered PHT write plus a mispredict pulse.
module br_update_queue
  import br_update_queue_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  br_update_queue_if.slave    bus
);

  localparam logic [LOG_DEPTH-1:0] PTR_ONE  = LOG_DEPTH'(1);
  localparam logic [LOG_DEPTH:0]   CNT_ONE  = (LOG_DEPTH+1)'(1);
  localparam logic [LOG_DEPTH:0]   CNT_FULL = (LOG_DEPTH+1)'(DEPTH);

  logic [LOG_DEPTH-1:0] head;
  logic [LOG_DEPTH-1:0] tail;
  logic [LOG_DEPTH:0]   count;
  logic                 ready;
  logic [LOG_INDEX-1:0] wt_index;
  logic                 wt_we;
  logic                 wt_dir;
  logic                 mispredict;
  logic                 underflow;

  logic [LOG_DEPTH-1:0] head_next;
  logic [LOG_DEPTH-1:0] tail_next;
  logic [LOG_DEPTH:0]   count_next;
  logic                 do_push;
  logic                 do_retire;
  uq_entry_t            wr_entry;
  uq_entry_t            rd_entry;
  logic [ENTRY_W-1:0]   rd_raw;

  assign wr_entry.pht_index = bus.fe_pht_index_i;
  assign wr_entry.pred_dir  = bus.fe_pred_dir_i;
  assign rd_entry           = uq_entry_t'(rd_raw);

  br_uq_ram u_ram (
    .clock (clock),
    .we    (do_push),
    .waddr (tail),
    .wdata (wr_entry),
    .raddr (head),
    .rdata (rd_raw)
  );

  // Decide which operations take effect and where the pointers move.
  // A retire is handled before a flush, so the flush rewinds the tail to
  // the already-advanced head; pushes in a flush cycle are discarded.
  always_comb begin
    do_push    = bus.fe_push_i & ready & ~bus.flush_i;
    do_retire  = bus.rt_valid_i & (count != '0);
    head_next  = do_retire ? head + PTR_ONE : head;
    tail_next  = tail;
    count_next = count;
    if (bus.flush_i) begin
      tail_next  = head_next;
      count_next = '0;
    end else begin
      tail_next = do_push ? tail + PTR_ONE : tail;
      case ({do_push, do_retire})
        2'b10:   count_next = count + CNT_ONE;
        2'b01:   count_next = count - CNT_ONE;
        default: count_next = count;
      endcase
    end
  end

  // Pointer, occupancy and registered ready state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ready <= 1'b1;
    end else begin
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next;
      ready <= (count_next != CNT_FULL);
    end
  end

  // PHT update, mispredict and sticky underflow outputs, one cycle after retire.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wt_index   <= '0;
      wt_we      <= 1'b0;
      wt_dir     <= 1'b0;
      mispredict <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      wt_we      <= do_retire;
      mispredict <= do_retire & (rd_entry.pred_dir ^ bus.rt_brdir_i);
      underflow  <= underflow | (bus.rt_valid_i & (count == '0));
      if (do_retire) begin
        wt_index <= rd_entry.pht_index;
        wt_dir   <= bus.rt_brdir_i;
      end
    end
  end

  assign bus.fe_ready_o        = ready;
  assign bus.count_o           = count;
  assign bus.pht_wt_index_o    = wt_index;
  assign bus.pht_cm_brdir_we_o = wt_we;
  assign bus.pht_cm_brdir_o    = wt_dir;
  assign bus.br_mispredict_o   = mispredict;
  assign bus.underflow_err_o   = underflow;

endmodule

// File: tb/tb_br_update_queue.sv
// Self-checking bench for br_update_queue: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_br_update_queue;
  import br_update_queue_pkg::*;

  logic clock;
  logic reset_n;
  int   compared;
  int   mismatched;

  br_update_queue_if uq_if ();

  br_update_queue dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (uq_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state: pending branches in program order plus the
  // last PHT write that was issued.
  typedef struct {
    int idx;
    bit pred;
  } ref_entry_t;

  ref_entry_t ref_q[$];
  int ref_idx;
  bit ref_dir;
  bit ref_we;
  bit ref_mis;
  bit ref_uf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ref_q.delete();
    ref_idx = 0;
    ref_dir = 1'b0;
    ref_we  = 1'b0;
    ref_mis = 1'b0;
    ref_uf  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(uq_if.count_o), 32'(ref_q.size()));
    chk({tag, ".ready"}, 32'(uq_if.fe_ready_o), 32'(ref_q.size() != DEPTH));
    chk({tag, ".we"}, 32'(uq_if.pht_cm_brdir_we_o), 32'(ref_we));
    chk({tag, ".mispredict"}, 32'(uq_if.br_mispredict_o), 32'(ref_mis));
    chk({tag, ".underflow"}, 32'(uq_if.underflow_err_o), 32'(ref_uf));
    chk({tag, ".index"}, 32'(uq_if.pht_wt_index_o), 32'(ref_idx));
    chk({tag, ".dir"}, 32'(uq_if.pht_cm_brdir_o), 32'(ref_dir));
  endtask

  // One clock cycle: apply inputs, let the edge happen, advance the model, compare.
  task automatic step(input string tag, input bit push, input int idx, input bit pred,
                      input bit rt, input bit dir, input bit fl);
    bit room;
    ref_entry_t e;
    uq_if.fe_push_i      = push;
    uq_if.fe_pht_index_i = idx[LOG_INDEX-1:0];
    uq_if.fe_pred_dir_i  = pred;
    uq_if.rt_valid_i     = rt;
    uq_if.rt_brdir_i     = dir;
    uq_if.flush_i        = fl;
    @(posedge clock);
    #1;
    room    = (ref_q.size() != DEPTH);
    ref_we  = 1'b0;
    ref_mis = 1'b0;
    if (rt) begin
      if (ref_q.size() > 0) begin
        e       = ref_q.pop_front();
        ref_we  = 1'b1;
        ref_idx = e.idx;
        ref_dir = dir;
        ref_mis = (e.pred != dir);
      end else begin
        ref_uf = 1'b1;
      end
    end
    if (fl) begin
      ref_q.delete();
    end else if (push && room) begin
      e.idx  = idx % (1 << LOG_INDEX);
      e.pred = pred;
      ref_q.push_back(e);
    end
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    uq_if.fe_push_i      = 1'b0;
    uq_if.fe_pht_index_i = '0;
    uq_if.fe_pred_dir_i  = 1'b0;
    uq_if.rt_valid_i     = 1'b0;
    uq_if.rt_brdir_i     = 1'b0;
    uq_if.flush_i        = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // 1: single branch, predicted taken, resolved not-taken.
    step("t1_push", 1'b1, 'h155, 1'b1, 1'b0, 1'b0, 1'b0);
    step("t1_retire", 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t1_idx_const", 32'(uq_if.pht_wt_index_o), 32'h155);
    chk("t1_mis_const", 32'(uq_if.br_mispredict_o), 32'd1);
    idle("t1_idle");

    // 2: fill to full, drop the extra push, drain in order.
    for (int i = 0; i < DEPTH; i++)
      step("t2_fill", 1'b1, i, i[0], 1'b0, 1'b0, 1'b0);
    chk("t2_ready_full", 32'(uq_if.fe_ready_o), 32'd0);
    step("t2_drop", 1'b1, 'h3FF, 1'b1, 1'b0, 1'b0, 1'b0);
    step("t2_full_pushret", 1'b1, 'h3FE, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < DEPTH; i++)
      step("t2_drain", 1'b0, 0, 1'b0, 1'b1, 1'($urandom_range(1)), 1'b0);
    idle("t2_idle");

    // 3: pointer wrap.
    for (int i = 0; i < 10; i++) step("t3_push_a", 1'b1, 'h100 + i, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step("t3_ret_a", 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step("t3_push_b", 1'b1, 'h200 + i, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step("t3_ret_b", 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0);

    // 4: retire + flush + push in the same cycle with 5 entries queued.
    for (int i = 0; i < 5; i++) step("t4_push", 1'b1, 'h050 + i, 1'b1, 1'b0, 1'b0, 1'b0);
    step("t4_flush", 1'b1, 'h2AA, 1'b0, 1'b1, 1'b0, 1'b1);
    idle("t4_after");
    step("t4_flush_empty", 1'b1, 'h2AB, 1'b0, 1'b0, 1'b0, 1'b1);

    // 5: retire on empty queue, alone and with a same-cycle push.
    step("t5_uf", 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("t5_uf_push", 1'b1, 'h077, 1'b0, 1'b1, 1'b1, 1'b0);
    step("t5_drain", 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle("t5_sticky");

    // Random traffic.
    for (int n = 0; n < 400; n++)
      step("rand", 1'($urandom_range(99) < 60), int'($urandom_range(1023)),
           1'($urandom_range(1)), 1'($urandom_range(99) < 50), 1'($urandom_range(1)),
           1'($urandom_range(99) < 4));

    // 6: reset while a PHT write is registered.
    for (int i = 0; i < 3; i++) step("t6_push", 1'b1, 'h3C0 + i, 1'b1, 1'b0, 1'b0, 1'b0);
    step("t6_retire", 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("t6_reset");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    idle("t6_after");
    step("t6_push2", 1'b1, 'h011, 1'b0, 1'b0, 1'b0, 1'b0);
    step("t6_ret2", 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
